// File: rtl/pipelined_addsub.sv
// ---------------------------------------------------------------------------
// pipelined_addsub
//
// Pipelined two's-complement adder/subtractor with valid/ready handshakes.
// The WIDTH-bit operation is cut into STAGES chunks of CW = WIDTH/STAGES bits.
// Stage k adds chunk k of A and the effective B plus the carry registered by
// stage k-1. The carry chain inside one clock period is therefore only CW bits
// long, plus the overflow XOR in the last stage.
//
// Operand chunk k is skewed by k cycles so that it meets its carry. Sum chunk
// k is then delayed by STAGES-1-k cycles so that all chunks of one operation
// leave together. A beat accepted in cycle n is presented with out_valid = 1
// in cycle n+STAGES.
//
// Backpressure is a single global stall: when a result is presented and not
// taken, every register in the block holds its value.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous, active-high reset (flushes every in-flight beat)
//   in_valid   operand beat present
//   in_ready   block accepts a beat this cycle (combinational, = !stall)
//   A, B       WIDTH-bit operands
//   Cin        carry-in when adding, borrow-in when subtracting
//   Sub        0 = A + B + Cin, 1 = A - B - Cin
//   out_valid  result present
//   out_ready  consumer takes the result this cycle
//   S          WIDTH-bit sum or difference
//   Cout       raw carry out of the MSB (subtract: 1 = no borrow)
//   Ovf        signed overflow
// ---------------------------------------------------------------------------
module pipelined_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);

    localparam int CW = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipelined_addsub: STAGES must lie in 1..WIDTH and divide WIDTH");
    end

    // -----------------------------------------------------------------------
    // Handshake and global stall
    // -----------------------------------------------------------------------
    logic              w_stall;
    logic              w_advance;
    logic              w_accept;
    logic [STAGES-1:0] r_valid;

    // Only a presented-but-untaken result stalls; an empty output slot never
    // blocks the pipeline even if out_ready is low.
    assign w_stall   = r_valid[STAGES-1] & ~out_ready;
    assign w_advance = ~w_stall;
    assign w_accept  = in_valid & ~w_stall;

    assign in_ready  = ~w_stall;
    assign out_valid = r_valid[STAGES-1];

    // One valid bit per stage. A bubble enters as 0 whenever no beat is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (w_advance) begin
            r_valid[0] <= w_accept;
            for (int k = 1; k < STAGES; k++) begin
                r_valid[k] <= r_valid[k-1];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Effective operands: subtraction is A + ~B + ~Cin, so that Cin acts as a
    // borrow-in and Cout reads as "no borrow".
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] w_b_adj;
    logic             w_c0;

    assign w_b_adj = Sub ? ~B : B;
    assign w_c0    = Sub ? ~Cin : Cin;

    // w_carry[k] is the carry into chunk k. Entry 0 is the effective
    // carry-in. Entry k > 0 is the registered carry of stage k-1. The last
    // entry is the carry out of the MSB.
    logic [STAGES:0]  w_carry;
    logic [WIDTH-1:0] w_s_aligned;
    logic             r_ovf;

    assign w_carry[0] = w_c0;

    // -----------------------------------------------------------------------
    // One generate block per chunk: input skew, chunk adder, output deskew.
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_chunk
        localparam int LO      = gi * CW;
        localparam int SKEW    = gi;
        localparam int OUT_DLY = STAGES - 1 - gi;

        logic [CW-1:0] w_a_op;
        logic [CW-1:0] w_b_op;
        logic [CW-1:0] w_sum;
        logic          w_cout;
        logic [CW-1:0] r_sum;
        logic          r_carry;

        // ---- input skew: chunk gi waits gi cycles for its carry ----
        if (SKEW == 0) begin : g_no_skew
            assign w_a_op = A[LO +: CW];
            assign w_b_op = w_b_adj[LO +: CW];
        end else begin : g_skew
            logic [CW-1:0] r_a_skew [SKEW];
            logic [CW-1:0] r_b_skew [SKEW];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int d = 0; d < SKEW; d++) begin
                        r_a_skew[d] <= '0;
                        r_b_skew[d] <= '0;
                    end
                end else if (w_advance) begin
                    r_a_skew[0] <= A[LO +: CW];
                    r_b_skew[0] <= w_b_adj[LO +: CW];
                    for (int d = 1; d < SKEW; d++) begin
                        r_a_skew[d] <= r_a_skew[d-1];
                        r_b_skew[d] <= r_b_skew[d-1];
                    end
                end
            end

            assign w_a_op = r_a_skew[SKEW-1];
            assign w_b_op = r_b_skew[SKEW-1];
        end

        // ---- chunk adder: the only carry path within one cycle ----
        assign {w_cout, w_sum} = {1'b0, w_a_op} + {1'b0, w_b_op} + {{CW{1'b0}}, w_carry[gi]};

        always_ff @(posedge clk) begin
            if (rst) begin
                r_sum   <= '0;
                r_carry <= 1'b0;
            end else if (w_advance) begin
                r_sum   <= w_sum;
                r_carry <= w_cout;
            end
        end

        assign w_carry[gi+1] = r_carry;

        // ---- signed overflow, computed alongside the MSB chunk ----
        if (gi == STAGES - 1) begin : g_ovf
            logic w_c_into_msb;

            // The sum bit is a ^ b ^ carry-in, so the carry into the MSB can
            // be recovered from the MSB sum bit and its two operand bits.
            assign w_c_into_msb = w_sum[CW-1] ^ w_a_op[CW-1] ^ w_b_op[CW-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (w_advance) begin
                    r_ovf <= w_c_into_msb ^ w_cout;
                end
            end
        end

        // ---- output deskew: realign chunk gi with the last chunk ----
        if (OUT_DLY == 0) begin : g_no_deskew
            assign w_s_aligned[LO +: CW] = r_sum;
        end else begin : g_deskew
            logic [CW-1:0] r_deskew [OUT_DLY];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int d = 0; d < OUT_DLY; d++) begin
                        r_deskew[d] <= '0;
                    end
                end else if (w_advance) begin
                    r_deskew[0] <= r_sum;
                    for (int d = 1; d < OUT_DLY; d++) begin
                        r_deskew[d] <= r_deskew[d-1];
                    end
                end
            end

            assign w_s_aligned[LO +: CW] = r_deskew[OUT_DLY-1];
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign S    = w_s_aligned;
    assign Cout = w_carry[STAGES];
    assign Ovf  = r_ovf;

endmodule

// File: tb/tb_pipelined_addsub.sv
`timescale 1ns/1ps
// Bench for pipelined_addsub: directed vector table on a WIDTH=16/STAGES=4
// instance, a streaming sequence with a mid-stream stall, a reset flush
// sequence, and a random stream. The random stream runs against the STAGES=4
// instance under random backpressure, and concurrently against STAGES=1, 2
// and 16 instances.
module tb_pipelined_addsub;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        cout;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
    } beat_t;

    typedef struct {
        logic [15:0] s;
        logic        cout;
        logic        ovf;
    } res_t;

    // ---- main DUT (WIDTH=16, STAGES=4) ----
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        cout;
    logic        ovf;

    int n_checks;
    int n_fail;

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(16), .STAGES(4)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (a),
        .B        (b),
        .Cin      (cin),
        .Sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .S        (s),
        .Cout     (cout),
        .Ovf      (ovf)
    );

    // ---- extra depths (STAGES = 1, 2, 16), never backpressured ----
    logic        x_in_valid;
    logic [15:0] x_a;
    logic [15:0] x_b;
    logic        x_cin;
    logic        x_sub;
    logic        x_out_ready;
    logic        x_ir [3];
    logic        x_ov [3];
    logic [15:0] x_s  [3];
    logic        x_co [3];
    logic        x_of [3];

    assign x_out_ready = 1'b1;

    for (genvar gi = 0; gi < 3; gi++) begin : g_x
        localparam int XS = (gi == 0) ? 1 : ((gi == 1) ? 2 : 16);
        pipelined_addsub #(.WIDTH(16), .STAGES(XS)) u_x (
            .clk      (clk),
            .rst      (rst),
            .in_valid (x_in_valid),
            .in_ready (x_ir[gi]),
            .A        (x_a),
            .B        (x_b),
            .Cin      (x_cin),
            .Sub      (x_sub),
            .out_valid(x_ov[gi]),
            .out_ready(x_out_ready),
            .S        (x_s[gi]),
            .Cout     (x_co[gi]),
            .Ovf      (x_of[gi])
        );
    end

    // History of beats offered to the extra instances, indexed by cycle.
    beat_t ring   [32];
    logic  ring_v [32];

    function automatic int xst(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 16);
    endfunction

    // Golden model: plain 17-bit arithmetic, with overflow taken from operand
    // and result signs.
    function automatic res_t golden(input beat_t bt);
        res_t        r;
        logic [15:0] bb;
        logic        c0;
        logic [16:0] full;
        bb     = bt.sub ? ~bt.b : bt.b;
        c0     = bt.sub ? ~bt.cin : bt.cin;
        full   = {1'b0, bt.a} + {1'b0, bb} + {16'd0, c0};
        r.s    = full[15:0];
        r.cout = full[16];
        r.ovf  = (bt.a[15] == bb[15]) && (r.s[15] != bt.a[15]);
        return r;
    endfunction

    function automatic beat_t make_beat(input int i, input bit rnd);
        beat_t bt;
        if (rnd) begin
            bt.a   = 16'($urandom);
            bt.b   = 16'($urandom);
            bt.cin = 1'($urandom_range(1));
            bt.sub = 1'($urandom_range(1));
        end else begin
            bt.a   = 16'(i);
            bt.b   = 16'(i) << 8;
            bt.cin = 1'b0;
            bt.sub = i[0];
        end
        return bt;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Streams nb beats into the main DUT. rnd = 0: A=i, B=0x100*i, Sub=i[0],
    // out_ready low in cycles 5..7. rnd = 1: random data, random in_valid and
    // out_ready, and random beats into the extra instances.
    task automatic run_stream(input int nb, input bit rnd, output int t_last, output int n_stall);
        beat_t pend;
        beat_t exp_q[$];
        beat_t bt;
        res_t  r;
        int    issued;
        int    got;
        int    cyc;
        int    t;
        bit    hold;
        logic  ev;
        issued  = 0;
        got     = 0;
        cyc     = 0;
        hold    = 1'b0;
        t_last  = -1;
        n_stall = 0;
        pend    = make_beat(0, rnd);
        for (int i = 0; i < 32; i++) ring_v[i] = 1'b0;
        while (got < nb && cyc < 3000) begin
            in_valid  = (issued < nb) && (!rnd || hold || ($urandom_range(3) != 0));
            a         = pend.a;
            b         = pend.b;
            cin       = pend.cin;
            sub       = pend.sub;
            out_ready = rnd ? ($urandom_range(2) != 0) : !(cyc >= 5 && cyc <= 7);
            if (rnd && issued < nb) begin
                x_in_valid = ($urandom_range(3) != 0);
                x_a        = 16'($urandom);
                x_b        = 16'($urandom);
                x_cin      = 1'($urandom_range(1));
                x_sub      = 1'($urandom_range(1));
            end else begin
                x_in_valid = 1'b0;
            end
            @(negedge clk);
            chk("in_ready_vs_stall", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (!in_ready) n_stall++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL stream_extra_result: got S=0x%04h with no beat outstanding, want none", s);
                end else begin
                    bt = exp_q.pop_front();
                    r  = golden(bt);
                    $display("beat %0d: A=%04h B=%04h Cin=%0d Sub=%0d -> S=%04h Cout=%0d Ovf=%0d",
                             got, bt.a, bt.b, bt.cin, bt.sub, s, cout, ovf);
                    chk("stream_S", 32'(s), 32'(r.s));
                    chk("stream_Cout", 32'(cout), 32'(r.cout));
                    chk("stream_Ovf", 32'(ovf), 32'(r.ovf));
                end
                got++;
                t_last = cyc;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(pend);
                issued++;
                pend = make_beat(issued, rnd);
                hold = 1'b0;
            end else begin
                hold = in_valid;
            end
            if (rnd) begin
                ring_v[cyc % 32] = x_in_valid;
                ring[cyc % 32]   = '{x_a, x_b, x_cin, x_sub};
                for (int k = 0; k < 3; k++) begin
                    t  = cyc - xst(k);
                    ev = (t >= 0) ? ring_v[t % 32] : 1'b0;
                    chk($sformatf("x%0d_in_ready", xst(k)), 32'(x_ir[k]), 32'(1));
                    chk($sformatf("x%0d_out_valid", xst(k)), 32'(x_ov[k]), 32'(ev));
                    if (ev) begin
                        r = golden(ring[t % 32]);
                        chk($sformatf("x%0d_S", xst(k)), 32'(x_s[k]), 32'(r.s));
                        chk($sformatf("x%0d_Cout", xst(k)), 32'(x_co[k]), 32'(r.cout));
                        chk($sformatf("x%0d_Ovf", xst(k)), 32'(x_of[k]), 32'(r.ovf));
                    end
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid   = 1'b0;
        x_in_valid = 1'b0;
        out_ready  = 1'b1;
        chk("stream_results_received", 32'(got), 32'(nb));
    endtask

    vec_t vecs [10];

    initial begin
        int lat;
        int t_last;
        int n_stall;
        int seen;

        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        cin        = 1'b0;
        sub        = 1'b0;
        out_ready  = 1'b1;
        x_in_valid = 1'b0;
        x_a        = '0;
        x_b        = '0;
        x_cin      = 1'b0;
        x_sub      = 1'b0;

        //            A         B        Cin   Sub   S         Cout  Ovf
        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0};
        vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[8] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[9] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'(0));
        chk("reset_in_ready", 32'(in_ready), 32'(1));
        chk("reset_S", 32'(s), 32'(0));
        chk("reset_Cout", 32'(cout), 32'(0));
        chk("reset_Ovf", 32'(ovf), 32'(0));
        for (int k = 0; k < 3; k++) chk("reset_x_out_valid", 32'(x_ov[k]), 32'(0));
        @(posedge clk);
        #1;

        // ---- directed vector table, one beat at a time ----
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a        = vecs[i].a;
            b        = vecs[i].b;
            cin      = vecs[i].cin;
            sub      = vecs[i].sub;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat      = 1;
            while (lat <= 20) begin
                @(negedge clk);
                if (out_valid) break;
                @(posedge clk);
                #1;
                lat++;
            end
            $display("vec %0d: A=%04h B=%04h Cin=%0d Sub=%0d -> S=%04h Cout=%0d Ovf=%0d latency=%0d",
                     i, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, s, cout, ovf, lat);
            chk("vec_latency", 32'(lat), 32'(4));
            chk("vec_S", 32'(s), 32'(vecs[i].s));
            chk("vec_Cout", 32'(cout), 32'(vecs[i].cout));
            chk("vec_Ovf", 32'(ovf), 32'(vecs[i].ovf));
            @(posedge clk);
            #1;
        end

        // ---- 8 back-to-back beats, out_ready low for 3 cycles ----
        run_stream(8, 1'b0, t_last, n_stall);
        chk("stream_total_cycles", 32'(t_last + 1), 32'(8 + 4 + 3));
        chk("stream_stall_cycles", 32'(n_stall), 32'(3));

        // ---- reset with 3 beats in flight (plus a beat offered during rst) ----
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = 16'h1000 + 16'(i);
            b        = 16'h0001;
            cin      = 1'b0;
            sub      = 1'b0;
            @(posedge clk);
            #1;
        end
        a   = 16'h0777;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b1;
        a        = 16'h0042;
        b        = 16'h0001;
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 32'(0));
        chk("flush_S", 32'(s), 32'(0));
        chk("flush_Cout", 32'(cout), 32'(0));
        chk("flush_Ovf", 32'(ovf), 32'(0));
        chk("flush_in_ready", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        seen     = 0;
        lat      = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (out_valid) begin
                seen++;
                $display("post-flush result %0d: S=%04h Cout=%0d Ovf=%0d at cycle %0d", seen, s, cout, ovf, c);
                if (seen == 1) begin
                    lat = c;
                    chk("post_flush_S", 32'(s), 32'(16'h0043));
                end
            end
            @(posedge clk);
            #1;
        end
        chk("post_flush_result_count", 32'(seen), 32'(1));
        chk("post_flush_latency", 32'(lat), 32'(4));

        // ---- random regression on all depths ----
        run_stream(200, 1'b1, t_last, n_stall);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
